spi_target_bridge: RTL and testbench
====================================

// Module: spi_target_bridge
// PURPOSE
//  SPI target (peripheral) front-end that receives bytes from the SoC SPI controller and
//  returns bytes to it, synchronous to the system clock.
//  Oversamples sclk/cs/pico through 2-FF synchronizers, so no logic is clocked by sclk.
//  Exposes received bytes as a valid pulse and accepts reply bytes via valid/ready.
//  Sits on the far end of the sclk/pico/poci/cs wires, downstream of the controller, in
//  hardware benches and loopback targets.
// PARAMETERS
//  CPOL  0  idle level of sclk; leading edge is rising if 0, falling if 1
//  CPHA  0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
// PORTS
//  clock      in   1  system clock; must be >= 8x the sclk frequency
//  reset      in   1  asynchronous, active-high reset
//  sclk       in   1  SPI clock from controller (asynchronous)
//  pico       in   1  serial data from controller, MSB first
//  cs         in   1  chip select, active-low
//  poci       out  1  serial data to controller (drive value)
//  poci_oe    out  1  poci output enable; the top level builds the tri-state buffer
//  rx_data    out  8  last complete received byte
//  rx_valid   out  1  one-cycle pulse: rx_data updated
//  tx_data    in   8  next reply byte
//  tx_valid   in   1  tx_data offered
//  tx_ready   out  1  one-entry tx holding register is empty
//  underrun   out  1  one-cycle pulse: byte started with the tx holding register empty
// BEHAVIOUR
//  Reset values: poci=0, poci_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=1, underrun=0,
//  state=IDLE, bit_cnt=0, synchronizers=idle levels (sclk=CPOL, cs=1, pico=0).
//  Sync: sclk/cs/pico pass through 2 FFs; edges are detected against a 3rd registered copy.
//  Sync + detect latency is 3 clock cycles, applied equally to all three signals.
//  Leading edge = sync sclk transitions away from CPOL; trailing edge = back to CPOL.
//  Sample edge = leading if CPHA=0, else trailing. Shift edge is the other one.
//  Each sample: rx_shift <= {rx_shift[6:0], pico_sync}; bit_cnt increments mod 8.
//  On the 8th sample: rx_data <= completed byte, rx_valid=1 on the next cycle only.
//  No backpressure on rx; each new byte overwrites rx_data.
//  TX holding: capture tx_data when tx_valid && tx_ready; tx_ready then drops to 0.
//  A byte load empties the holding register; tx_ready=1 the cycle after the load.
//  A simultaneous load and tx handshake: the new data goes into the holding register.
//  Byte load copies holding -> tx_shift; if empty, loads 8'h00 and pulses underrun.
//  CPHA=0: load at cs falling edge and at each 8th shift edge while cs low.
//    poci = tx_shift[7] at load; every shift edge shifts left and updates poci.
//  CPHA=1: load at the leading edge with bit_cnt==0, then poci <= bit7.
//    Later leading edges shift and present the next bit.
//  FSM: IDLE --cs_sync fall--> ACTIVE; ACTIVE --cs_sync rise--> IDLE.
//  Edges are ignored in IDLE. poci_oe=1 only in ACTIVE.
//  cs rise mid-byte: partial rx bits discarded (no rx_valid), bit_cnt=0.
//    An unsent tx_shift is dropped; the holding register is kept.
//  An sclk edge in the same cycle as cs_sync rise is ignored.
//  Reset mid-transfer returns everything to reset values immediately (asynchronous).
// TESTING
//  1 Mode 0: hold tx 8'hA5, controller sends 8'h3C at clock/8.
//    Expect rx_data=8'h3C with one rx_valid pulse; controller reads 8'hA5; tx_ready back to 1.
//  2 CPOL=1,CPHA=1 build: same traffic.
//    Expect rx 8'h3C; controller reads 8'hA5; poci changes only on leading (falling) edges.
//  3 Two back-to-back bytes 8'h01,8'h80 under one cs, holding refilled with 8'h11 in between.
//    Expect two rx_valid pulses in order; reply 8'hA5 then 8'h11.
//  4 No tx loaded, controller sends 8'hFF.
//    Expect underrun pulse at byte start; controller reads 8'h00; rx_data=8'hFF.
//  5 cs raised after 5 bits, then a full byte 8'h5A.
//    Expect no rx_valid for the partial byte, then rx_data=8'h5A.
//    The holding byte is still sent in the new frame.
//  6 Assert reset mid-byte.
//    Expect all outputs at reset values with no clock edge needed; the next full frame works normally.

Source files
------------

// File: rtl/spi_target_bridge.sv
// SPI target front-end: oversamples sclk/cs/pico in the system clock domain, delivers
// received bytes as a valid pulse and takes reply bytes through a one-entry holding register.
module spi_target_bridge #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       underrun
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_pipe_q, sclk_pipe_d;
  logic [2:0]          cs_pipe_q, cs_pipe_d;
  logic [1:0]          pico_pipe_q, pico_pipe_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                tx_ready_q, tx_ready_d;
  logic                underrun_q, underrun_d;
  logic                poci_q, poci_d;
  logic                poci_oe_q, poci_oe_d;

  logic                lead_edge, trail_edge, sample_edge, shift_edge;
  logic                cs_fall, cs_rise;
  logic                do_load, do_shift;
  logic [BYTE_W-1:0]   load_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_pipe_q <= {3{CPOL}};
      cs_pipe_q   <= 3'b111;
      pico_pipe_q <= 2'b00;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      underrun_q  <= 1'b0;
      poci_q      <= 1'b0;
      poci_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_pipe_q <= sclk_pipe_d;
      cs_pipe_q   <= cs_pipe_d;
      pico_pipe_q <= pico_pipe_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      underrun_q  <= underrun_d;
      poci_q      <= poci_d;
      poci_oe_q   <= poci_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
    cs_pipe_d   = {cs_pipe_q[1:0], cs};
    pico_pipe_d = {pico_pipe_q[0], pico};
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    tx_ready_d  = tx_ready_q;
    underrun_d  = 1'b0;
    poci_d      = poci_q;
    do_load     = 1'b0;
    do_shift    = 1'b0;
    load_byte   = tx_ready_q ? '0 : hold_q;

    // Edges compare the second synchronizer stage against a third registered copy
    lead_edge   = (sclk_pipe_q[1] != sclk_pipe_q[2]) && (sclk_pipe_q[1] != CPOL);
    trail_edge  = (sclk_pipe_q[1] != sclk_pipe_q[2]) && (sclk_pipe_q[1] == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    cs_fall     = !cs_pipe_q[1] && cs_pipe_q[2];
    cs_rise     = cs_pipe_q[1] && !cs_pipe_q[2];

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          do_load   = !CPHA;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          tx_shift_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[BYTE_W-2:0], pico_pipe_q[1]};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              rx_data_d  = {rx_shift_q[BYTE_W-2:0], pico_pipe_q[1]};
              rx_valid_d = 1'b1;
            end
          end
          // A shift edge at a byte boundary loads the next reply instead of shifting
          if (shift_edge) begin
            if (bit_cnt_q == '0) do_load = 1'b1;
            else                 do_shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      tx_shift_d = load_byte;
      poci_d     = load_byte[BYTE_W-1];
      underrun_d = tx_ready_q;
      tx_ready_d = 1'b1;
    end else if (do_shift) begin
      tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
      poci_d     = tx_shift_q[BYTE_W-2];
    end

    // A handshake coinciding with a load refills the just-emptied holding register
    if (tx_valid && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    poci_oe_d = (state_d == ACTIVE);
  end

  assign poci     = poci_q;
  assign poci_oe  = poci_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_target_bridge.sv
// Bench for spi_target_bridge: a mode-0 and a mode-3 instance driven by a behavioural
// SPI controller, checked against a transaction-level model of the holding register.
module tb_spi_target_bridge;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] sclk, cs, pico, tx_valid;
  logic [1:0] poci, poci_oe, rx_valid, tx_ready, underrun;
  logic [7:0] tx_data [2];
  logic [7:0] rx_data [2];

  always #5 clock = ~clock;

  spi_target_bridge #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clock(clock), .reset(reset), .sclk(sclk[0]), .pico(pico[0]), .cs(cs[0]),
    .poci(poci[0]), .poci_oe(poci_oe[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .underrun(underrun[0])
  );

  spi_target_bridge #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clock(clock), .reset(reset), .sclk(sclk[1]), .pico(pico[1]), .cs(cs[1]),
    .poci(poci[1]), .poci_oe(poci_oe[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .underrun(underrun[1])
  );

  int checks, errors;
  int rx_cnt [2];
  int ur_cnt [2];
  int rx_exp [2];
  int ur_exp [2];
  logic       hold_v [2];
  logic [7:0] hold_b [2];
  logic [7:0] exp_sh [2];
  int   edge_err;
  logic last_lead;
  logic prev_poci1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and the mode-3 rule that poci only moves after leading edges
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid[i] === 1'b1) rx_cnt[i]++;
      if (underrun[i] === 1'b1) ur_cnt[i]++;
    end
    if (poci_oe[1] === 1'b1 && poci[1] !== prev_poci1 && !last_lead) edge_err++;
    prev_poci1 = poci[1];
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Model of a byte load: reply comes from the holding register, or zero with an underrun
  task automatic model_load(input int m);
    exp_sh[m] = hold_v[m] ? hold_b[m] : 8'h00;
    if (!hold_v[m]) ur_exp[m]++;
    hold_v[m] = 1'b0;
  endtask

  task automatic push_tx(input int m, input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("push_ready", 32'(tx_ready[m]), 32'd1);
    tx_data[m]  = b;
    tx_valid[m] = 1'b1;
    @(negedge clock);
    tx_valid[m] = 1'b0;
    hold_v[m] = 1'b1;
    hold_b[m] = b;
  endtask

  task automatic cs_low(input int m);
    cs[m] = 1'b0;
    if (m == 0) model_load(0);
    wait_clk(8);
  endtask

  task automatic cs_high(input int m);
    wait_clk(4);
    cs[m] = 1'b1;
    wait_clk(8);
  endtask

  // One byte (or nbits of it) from the controller's side; rd is what it read on poci
  task automatic xfer_byte(input int m, input logic [7:0] b, input int nbits,
                           input bit push_en, input logic [7:0] pb, output logic [7:0] rd);
    logic [7:0] exp_rd;
    if (m == 1) model_load(1);
    exp_rd = exp_sh[m];
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (m == 0) begin
        pico[0] = b[3'(7 - i)];
        wait_clk(4);
        rd = {rd[6:0], poci[0]};
        sclk[0] = 1'b1;
        wait_clk(4);
        sclk[0] = 1'b0;
      end else begin
        sclk[1]   = 1'b0;
        last_lead = 1'b1;
        pico[1]   = b[3'(7 - i)];
        wait_clk(4);
        rd = {rd[6:0], poci[1]};
        sclk[1]   = 1'b1;
        last_lead = 1'b0;
        wait_clk(4);
      end
      if (i == 3 && push_en) push_tx(m, pb);
    end
    if (nbits == 8) begin
      wait_clk(5);
      if (m == 0) model_load(0);
      rx_exp[m]++;
      chk("reply", 32'(rd), 32'(exp_rd));
      chk("rx_data", 32'(rx_data[m]), 32'(b));
      chk("rx_count", rx_cnt[m], rx_exp[m]);
    end
  endtask

  task automatic frame_end_checks(input int m);
    chk("underrun_count", ur_cnt[m], ur_exp[m]);
    chk("tx_ready", 32'(tx_ready[m]), 32'(!hold_v[m]));
  endtask

  initial begin
    logic [7:0] rd;
    int nb, m;
    checks = 0; errors = 0; edge_err = 0;
    last_lead = 1'b0; prev_poci1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_cnt[i] = 0; ur_cnt[i] = 0; rx_exp[i] = 0; ur_exp[i] = 0;
      hold_v[i] = 1'b0; hold_b[i] = 8'h00; exp_sh[i] = 8'h00;
      tx_data[i] = 8'h00;
    end
    reset = 1'b1;
    sclk = 2'b10; cs = 2'b11; pico = 2'b00; tx_valid = 2'b00;
    wait_clk(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_poci", 32'(poci[i]), 32'd0);
      chk("rst_poci_oe", 32'(poci_oe[i]), 32'd0);
      chk("rst_rx_data", 32'(rx_data[i]), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid[i]), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready[i]), 32'd1);
      chk("rst_underrun", 32'(underrun[i]), 32'd0);
    end
    reset = 1'b0;
    wait_clk(4);

    // Mode 0 and mode 3: A5 held, 3C sent
    for (int k = 0; k < 2; k++) begin
      push_tx(k, 8'hA5);
      cs_low(k);
      xfer_byte(k, 8'h3C, 8, 1'b0, 8'h00, rd);
      chk("single_reply", 32'(rd), 32'hA5);
      cs_high(k);
      frame_end_checks(k);
    end

    // Back-to-back bytes with a refill during the first
    push_tx(0, 8'hA5);
    cs_low(0);
    xfer_byte(0, 8'h01, 8, 1'b1, 8'h11, rd);
    chk("b2b_reply0", 32'(rd), 32'hA5);
    xfer_byte(0, 8'h80, 8, 1'b0, 8'h00, rd);
    chk("b2b_reply1", 32'(rd), 32'h11);
    cs_high(0);
    frame_end_checks(0);

    // Empty holding register at byte start
    cs_low(0);
    xfer_byte(0, 8'hFF, 8, 1'b0, 8'h00, rd);
    chk("underrun_reply", 32'(rd), 32'h00);
    cs_high(0);
    frame_end_checks(0);

    // Aborted frame after 5 bits; the byte refilled meanwhile goes out next frame
    push_tx(0, 8'h77);
    cs_low(0);
    xfer_byte(0, 8'hE1, 5, 1'b1, 8'hC6, rd);
    cs_high(0);
    chk("partial_no_rx", rx_cnt[0], rx_exp[0]);
    cs_low(0);
    xfer_byte(0, 8'h5A, 8, 1'b0, 8'h00, rd);
    chk("after_abort_reply", 32'(rd), 32'hC6);
    cs_high(0);
    frame_end_checks(0);

    // Asynchronous reset in the middle of a byte
    push_tx(0, 8'h3C);
    cs_low(0);
    xfer_byte(0, 8'h99, 3, 1'b0, 8'h00, rd);
    pico[0] = 1'b1;
    wait_clk(2);
    sclk[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_poci", 32'(poci[0]), 32'd0);
    chk("async_poci_oe", 32'(poci_oe[0]), 32'd0);
    chk("async_rx_data", 32'(rx_data[0]), 32'd0);
    chk("async_tx_ready", 32'(tx_ready[0]), 32'd1);
    chk("async_underrun", 32'(underrun[0]), 32'd0);
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    cs[0] = 1'b1; sclk[0] = 1'b0; pico[0] = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    chk("reset_no_rx", rx_cnt[0], rx_exp[0]);
    push_tx(0, 8'h4D);
    cs_low(0);
    xfer_byte(0, 8'h96, 8, 1'b0, 8'h00, rd);
    chk("post_reset_reply", 32'(rd), 32'h4D);
    cs_high(0);
    frame_end_checks(0);

    // Randomized frames alternating between the two modes
    for (int f = 0; f < 16; f++) begin
      m  = f % 2;
      nb = int'($urandom_range(1, 3));
      if (!hold_v[m] && $urandom_range(0, 1) == 1) push_tx(m, 8'($urandom));
      cs_low(m);
      for (int k = 0; k < nb; k++)
        xfer_byte(m, 8'($urandom), 8, 1'($urandom_range(0, 1)), 8'($urandom), rd);
      cs_high(m);
      frame_end_checks(m);
    end

    chk("poci_lead_only", edge_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
